// File: rtl/maze_move_sequencer_if.sv
// Bundles the move requests, the map ROM port and the player/status
// outputs of the maze move sequencer.
interface maze_move_sequencer_if #(
   parameter int unsigned MAP_W = 30,
   parameter int unsigned ADDRW = 5
);
   logic [3:0]       move_req;
   logic [ADDRW-1:0] rom_addr;
   logic [MAP_W-1:0] rom_data;
   logic [7:0]       player_x_pos;
   logic [7:0]       player_y_pos;
   logic             busy;
   logic             blocked;
   logic             lost;
   logic             won;
   logic [15:0]      move_count;

   // Environment side: drives move requests and returns map rows.
   modport master (
      output move_req,
      output rom_data,
      input  rom_addr,
      input  player_x_pos,
      input  player_y_pos,
      input  busy,
      input  blocked,
      input  lost,
      input  won,
      input  move_count
   );

   // Sequencer side.
   modport slave (
      input  move_req,
      input  rom_data,
      output rom_addr,
      output player_x_pos,
      output player_y_pos,
      output busy,
      output blocked,
      output lost,
      output won,
      output move_count
   );
endinterface

// File: rtl/maze_move_sequencer.sv
// Maze move sequencer: validates each move against the map edges, fetches the
// target row from the map ROM, then commits the move or ends the game on a wall.
module maze_move_sequencer #(
   parameter int unsigned MAP_W   = 30,
   parameter int unsigned MAP_H   = 21,
   parameter int unsigned ADDRW   = $clog2(MAP_H),
   parameter int unsigned ROM_LAT = 1,
   parameter int unsigned START_X = 0,
   parameter int unsigned START_Y = 20,
   parameter int unsigned GOAL_X  = 29,
   parameter int unsigned GOAL_Y  = 0
) (
   input logic                  clk,
   input logic                  reset,
   maze_move_sequencer_if.slave bus
);
   localparam int unsigned XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
   localparam int unsigned YW = ADDRW;
   localparam int unsigned CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StCheck, StOver} state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   x_q, cand_x_q, nxt_x;
   logic [YW-1:0]   y_q, cand_y_q, nxt_y;
   logic [ADDRW-1:0] rom_addr_q;
   logic [CW-1:0]   wait_q;
   logic            blocked_q, lost_q, won_q;
   logic [15:0]     count_q;
   logic            req_valid, edge_hit, wall, goal_hit;

   // Pick the highest-priority request and compute its target and edge status.
   always_comb begin
      req_valid = 1'b0;
      edge_hit  = 1'b0;
      nxt_x     = x_q;
      nxt_y     = y_q;
      if (bus.move_req[0]) begin
         req_valid = 1'b1;
         edge_hit  = (y_q == '0);
         nxt_y     = y_q - 1'b1;
      end else if (bus.move_req[1]) begin
         req_valid = 1'b1;
         edge_hit  = (y_q == YW'(MAP_H - 1));
         nxt_y     = y_q + 1'b1;
      end else if (bus.move_req[2]) begin
         req_valid = 1'b1;
         edge_hit  = (x_q == '0);
         nxt_x     = x_q - 1'b1;
      end else if (bus.move_req[3]) begin
         req_valid = 1'b1;
         edge_hit  = (x_q == XW'(MAP_W - 1));
         nxt_x     = x_q + 1'b1;
      end
   end

   assign wall     = bus.rom_data[cand_x_q];
   assign goal_hit = (cand_x_q == XW'(GOAL_X)) && (cand_y_q == YW'(GOAL_Y));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_valid && !edge_hit) state_d = StWait;
         StWait:  if (wait_q == '0) state_d = StCheck;
         StCheck: state_d = (wall || goal_hit) ? StOver : StIdle;
         StOver:  state_d = StOver;
         default: state_d = StIdle;
      endcase
   end

   // Datapath: candidate latch, ROM address, wait counter, commit and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q        <= XW'(START_X);
         y_q        <= YW'(START_Y);
         cand_x_q   <= '0;
         cand_y_q   <= '0;
         rom_addr_q <= ADDRW'(START_Y);
         wait_q     <= '0;
         blocked_q  <= 1'b0;
         lost_q     <= 1'b0;
         won_q      <= 1'b0;
         count_q    <= '0;
      end else begin
         blocked_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  if (edge_hit) begin
                     blocked_q <= 1'b1;
                  end else begin
                     cand_x_q   <= nxt_x;
                     cand_y_q   <= nxt_y;
                     rom_addr_q <= nxt_y;
                     wait_q     <= CW'(ROM_LAT - 1);
                  end
               end
            end
            StWait: begin
               if (wait_q != '0) wait_q <= wait_q - 1'b1;
            end
            StCheck: begin
               if (wall) begin
                  lost_q <= 1'b1;
               end else begin
                  x_q <= cand_x_q;
                  y_q <= cand_y_q;
                  if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
                  if (goal_hit) won_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs; busy only while a move is in flight.
   always_comb begin
      bus.rom_addr     = rom_addr_q;
      bus.player_x_pos = 8'(x_q);
      bus.player_y_pos = 8'(y_q);
      bus.busy         = (state_q == StWait) || (state_q == StCheck);
      bus.blocked      = blocked_q;
      bus.lost         = lost_q;
      bus.won          = won_q;
      bus.move_count   = count_q;
   end
endmodule

// File: tb/tb_maze_move_sequencer.sv
// Directed bench for maze_move_sequencer with a 1-cycle synchronous map ROM model.
module tb_maze_move_sequencer;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   logic [29:0] map [0:20];

   maze_move_sequencer_if #(.MAP_W(30), .ADDRW(5)) bus ();

   maze_move_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Map ROM: one-cycle registered read.
   always @(posedge clk) bus.rom_data <= map[bus.rom_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      step();
   endtask

   // One full move: request sampled at edge N, returns after edge N+2.
   task automatic do_move(input logic [3:0] req);
      bus.move_req = req;
      step();
      bus.move_req = 4'b0;
      step();
      step();
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      reset        = 1'b1;
      bus.move_req = 4'b0;
      for (int r = 0; r < 21; r++) map[r] = '0;
      map[19][0] = 1'b1;
      #12;
      reset = 1'b0;
      step();

      // Reset state
      check_eq("rst_x", bus.player_x_pos, 0);
      check_eq("rst_y", bus.player_y_pos, 20);
      check_eq("rst_addr", bus.rom_addr, 20);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_flags", {bus.blocked, bus.lost, bus.won}, 0);
      check_eq("rst_count", bus.move_count, 0);

      // Open move right from (0,20)
      bus.move_req = 4'b1000;
      step();
      bus.move_req = 4'b0;
      check_eq("open_busy_n", bus.busy, 1);
      check_eq("open_addr", bus.rom_addr, 20);
      check_eq("open_x_early", bus.player_x_pos, 0);
      step();
      check_eq("open_busy_n1", bus.busy, 1);
      check_eq("open_x_mid", bus.player_x_pos, 0);
      step();
      check_eq("open_x", bus.player_x_pos, 1);
      check_eq("open_count", bus.move_count, 1);
      check_eq("open_busy_done", bus.busy, 0);

      // Asynchronous reset mid-cycle
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_x", bus.player_x_pos, 0);
      check_eq("async_y", bus.player_y_pos, 20);
      check_eq("async_addr", bus.rom_addr, 20);
      check_eq("async_count", bus.move_count, 0);
      #2;
      reset = 1'b0;
      step();

      // Edge refusals at (0,20)
      bus.move_req = 4'b0100;
      step();
      bus.move_req = 4'b0;
      check_eq("edge_l_blk", bus.blocked, 1);
      check_eq("edge_l_busy", bus.busy, 0);
      check_eq("edge_l_addr", bus.rom_addr, 20);
      step();
      check_eq("edge_l_pulse", bus.blocked, 0);
      bus.move_req = 4'b0010;
      step();
      bus.move_req = 4'b0;
      check_eq("edge_d_blk", bus.blocked, 1);
      check_eq("edge_d_busy", bus.busy, 0);
      step();
      check_eq("edge_d_pulse", bus.blocked, 0);
      check_eq("edge_count", bus.move_count, 0);
      check_eq("edge_pos", {bus.player_x_pos, bus.player_y_pos}, {8'd0, 8'd20});

      // Wall up: row 19 bit 0 set
      do_move(4'b0001);
      check_eq("wall_lost", bus.lost, 1);
      check_eq("wall_won", bus.won, 0);
      check_eq("wall_y", bus.player_y_pos, 20);
      check_eq("wall_count", bus.move_count, 0);
      bus.move_req = 4'b1000;
      step();
      bus.move_req = 4'b0;
      check_eq("over_busy", bus.busy, 0);
      step();
      step();
      check_eq("over_x", bus.player_x_pos, 0);
      check_eq("over_lost", bus.lost, 1);

      // Priority and drop while busy
      map[19][0] = 1'b0;
      do_reset();
      bus.move_req = 4'b1001;
      step();
      bus.move_req = 4'b1000;
      step();
      bus.move_req = 4'b0;
      step();
      check_eq("prio_y", bus.player_y_pos, 19);
      check_eq("prio_x", bus.player_x_pos, 0);
      check_eq("prio_count", bus.move_count, 1);
      step();
      check_eq("drop_busy", bus.busy, 0);
      check_eq("drop_x", bus.player_x_pos, 0);

      // Walk column 0 up then row 0 right to the goal
      for (int r = 0; r < 21; r++) begin
         map[r]    = '1;
         map[r][0] = 1'b0;
      end
      map[0] = '0;
      do_reset();
      for (int i = 0; i < 20; i++) do_move(4'b0001);
      check_eq("walk_mid_y", bus.player_y_pos, 0);
      check_eq("walk_mid_won", bus.won, 0);
      for (int i = 0; i < 29; i++) do_move(4'b1000);
      check_eq("goal_won", bus.won, 1);
      check_eq("goal_lost", bus.lost, 0);
      check_eq("goal_pos", {bus.player_x_pos, bus.player_y_pos}, {8'd29, 8'd0});
      check_eq("goal_count", bus.move_count, 49);
      // Frozen in OVER: edge request must not pulse, wall request must not lose
      bus.move_req = 4'b1000;
      step();
      bus.move_req = 4'b0;
      check_eq("goal_noblk", bus.blocked, 0);
      do_move(4'b0010);
      check_eq("goal_frz_lost", bus.lost, 0);
      check_eq("goal_frz_y", bus.player_y_pos, 0);
      check_eq("goal_frz_count", bus.move_count, 49);

      // Reset while a move is in WAIT discards it
      do_reset();
      bus.move_req = 4'b1000;
      step();
      bus.move_req = 4'b0;
      check_eq("rw_busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("rw_busy_rst", bus.busy, 0);
      check_eq("rw_won_rst", bus.won, 0);
      #2;
      reset = 1'b0;
      step();
      step();
      check_eq("rw_x", bus.player_x_pos, 0);
      check_eq("rw_count", bus.move_count, 0);
      check_eq("rw_addr", bus.rom_addr, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
